// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a registered or FWFT read port.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 3,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 1,
    parameter int FWFT      = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_TH);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt;
    logic              rd_acc;
    logic              wr_acc;

    // Flags come straight from the count register: no extra latency.
    assign full         = (cnt == DEPTH_C);
    assign empty        = (cnt == '0);
    assign almost_full  = (cnt >= AFULL_C);
    assign almost_empty = (cnt <= AEMPTY_C);
    assign count        = cnt;

    // A full FIFO still takes a push when a pop frees a slot in the same cycle.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (wr_acc && !rd_acc) begin
                cnt <= cnt + CNT_ONE;
            end else if (rd_acc && !wr_acc) begin
                cnt <= cnt - CNT_ONE;
            end
            // A new error in the same cycle takes priority over the clear.
            if (wr_en && !wr_acc) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_en && !rd_acc) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_data  = mem[rd_ptr];
            assign rd_valid = !empty;
        end else begin : g_reg
            logic [DATA_W-1:0] rd_data_p1;
            logic              vld_p1;

            // Popped word lands one edge after the accepted pop.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data_p1 <= '0;
                    vld_p1     <= 1'b0;
                end else begin
                    vld_p1 <= rd_acc;
                    if (rd_acc) begin
                        rd_data_p1 <= mem[rd_ptr];
                    end
                end
            end

            assign rd_data  = rd_data_p1;
            assign rd_valid = vld_p1;
        end
    endgenerate

endmodule
